// File: rtl/taxi_disp_scan.sv
// taxi_disp_scan: double-dabble BCD converter and 8-digit seven-segment scanner for the taximeter
// Ports: clk/rst (sync, active-high); op selects fare/mileage/wait/blank; cost, mil, timee are binary values;
// seg is the active-low digit enable, codeout the {dp,g..a} segments, upd pulses while a result loads.
// Optional TAXI_LZB_EN enables leading-zero blanking.
module taxi_disp_scan #(
    parameter int SCAN_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  op,
    input  logic [10:0] cost,
    input  logic [7:0]  mil,
    input  logic [6:0]  timee,
    output logic [7:0]  seg,
    output logic [7:0]  codeout,
    output logic        upd
);
    localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    typedef enum logic [1:0] {LATCH, SHIFT, LOAD} state_t;
    state_t      state_q;
    logic [1:0]  op_l_q, disp_op_q;
    logic [10:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d, bcd_adj, disp_q;
    logic [3:0]  cnt_q, nib;
    logic [PW-1:0] presc_q;
    logic [2:0]  idx_q;
    logic        hide;
    logic [7:0]  code_d;
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 8'h3F;
            4'd1: seg7 = 8'h06;
            4'd2: seg7 = 8'h5B;
            4'd3: seg7 = 8'h4F;
            4'd4: seg7 = 8'h66;
            4'd5: seg7 = 8'h6D;
            4'd6: seg7 = 8'h7D;
            4'd7: seg7 = 8'h07;
            4'd8: seg7 = 8'h7F;
            4'd9: seg7 = 8'h6F;
            default: seg7 = 8'h00;
        endcase
    endfunction
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
    end
    always_comb begin
        nib = disp_q[{idx_q[1:0], 2'b00} +: 4];
`ifdef TAXI_LZB_EN
        // A digit is a leading zero when it and every more significant digit are zero;
        // digit 1 is only blanked for waiting time, which carries no decimal point.
        hide = idx_q == 3'd3 ? disp_q[15:12] == 4'd0 :
               idx_q == 3'd2 ? disp_q[15:8] == 8'd0 :
               idx_q == 3'd1 ? disp_q[15:4] == 12'd0 && disp_op_q == 2'd2 : 1'b0;
`else
        hide = 1'b0;
`endif
        code_d = disp_op_q == 2'd3 ? 8'h00 :
                 idx_q == 3'd7     ? seg7({2'b00, disp_op_q}) :
                 idx_q[2]          ? 8'h00 :
                 (hide ? 8'h00 : seg7(nib)) | {idx_q == 3'd1 && !disp_op_q[1], 7'b0};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LATCH;
            op_l_q    <= 2'd0;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
            disp_q    <= '0;
            disp_op_q <= 2'd3;
            upd       <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state_q)
                LATCH: begin
                    op_l_q  <= op;
                    bin_q   <= op == 2'd0 ? cost : op == 2'd1 ? {3'b0, mil} : op == 2'd2 ? {4'b0, timee} : 11'd0;
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    bcd_q <= bcd_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q + 4'd1;
                    // upd is raised on entry so it is high during the LOAD cycle itself
                    if (cnt_q == 4'd10) begin
                        state_q <= LOAD;
                        upd     <= 1'b1;
                    end
                end
                LOAD: begin
                    disp_q    <= bcd_q;
                    disp_op_q <= op_l_q;
                    state_q   <= LATCH;
                end
                default: state_q <= LATCH;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= 3'd0;
            seg     <= 8'hFF;
            codeout <= 8'h00;
        end else begin
            seg     <= ~(8'd1 << idx_q);
            codeout <= code_d;
            if (presc_q == PW'(SCAN_DIV - 1)) begin
                presc_q <= '0;
                idx_q   <= idx_q + 3'd1;
            end else begin
                presc_q <= presc_q + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_taxi_disp_scan.sv
// tb_taxi_disp_scan: randomized and directed checks of taxi_disp_scan against a decimal-arithmetic display model
module tb_taxi_disp_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  op = 2'd0;
    logic [10:0] cost = 11'd0;
    logic [7:0]  mil = 8'd0;
    logic [6:0]  timee = 7'd0;
    logic [7:0]  seg, codeout, seg4, codeout4;
    logic        upd, upd4;
    int total = 0;
    int fails = 0;
    localparam logic [7:0] SG [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    localparam int PWR [4] = '{1, 10, 100, 1000};
    always #5 clk = ~clk;
    taxi_disp_scan #(.SCAN_DIV(1)) u_dut (
        .clk(clk), .rst(rst), .op(op), .cost(cost), .mil(mil), .timee(timee),
        .seg(seg), .codeout(codeout), .upd(upd)
    );
    taxi_disp_scan #(.SCAN_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .op(op), .cost(cost), .mil(mil), .timee(timee),
        .seg(seg4), .codeout(codeout4), .upd(upd4)
    );
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] model_code(input int o, input int v, input int k);
        logic [7:0] c;
        if (o == 3 || (k >= 4 && k <= 6)) return 8'h00;
        if (k == 7) return SG[o];
        c = SG[(v / PWR[k]) % 10];
`ifdef TAXI_LZB_EN
        if (k >= (o == 2 ? 1 : 2) && v < PWR[k]) c = 8'h00;
`endif
        if (k == 1 && o != 2) c = c | 8'h80;
        return c;
    endfunction
    function automatic int sel_val(input int o, input int c, input int m, input int t);
        return o == 0 ? c : o == 1 ? m : o == 2 ? t : 0;
    endfunction
    task automatic wait_upd;
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step;
            seen = upd;
        end
        chk("upd_seen", 32'(seen), 32'd1);
    endtask
    task automatic scan_check(input string tag, input int o, input int v);
        step;
        step;
        for (int i = 0; i < 8; i++) begin
            int k = -1;
            step;
            for (int j = 0; j < 8; j++)
                if (seg === 8'(~(8'd1 << j))) k = j;
            chk($sformatf("%s_seg_onehot", tag), 32'(k >= 0), 32'd1);
            if (k >= 0) chk($sformatf("%s_d%0d", tag, k), 32'(codeout), 32'(model_code(o, v, k)));
        end
    endtask
    task automatic run_case(input string tag, input int o, input int c, input int m, input int t);
        op = 2'(o);
        cost = 11'(c);
        mil = 8'(m);
        timee = 7'(t);
        wait_upd;
        wait_upd;
        scan_check(tag, o, sel_val(o, c, m, t));
    endtask
    initial begin
        repeat (3) step;
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_code", 32'(codeout), 32'h00);
        chk("rst_upd", 32'(upd), 32'd0);
        chk("rst_seg4", 32'(seg4), 32'hFF);
        rst = 1'b0;
        for (int k = 1; k <= 39; k++) begin
            step;
            chk($sformatf("upd_cyc%0d", k + 1), 32'(upd), 32'((k + 1) % 13 == 0));
            chk($sformatf("scan_cyc%0d", k + 1), 32'(seg), 32'(8'(~(8'd1 << ((k - 1) % 8)))));
            chk($sformatf("scan4_cyc%0d", k + 1), 32'(seg4), 32'(8'(~(8'd1 << (((k - 1) / 4) % 8)))));
        end
        run_case("fare123", 0, 123, 0, 0);
        run_case("mil5", 1, 0, 5, 0);
        run_case("wait0", 2, 0, 0, 0);
        run_case("fare2047", 0, 2047, 0, 0);
        run_case("blank", 3, 2047, 255, 127);
        run_case("wait127", 2, 0, 0, 127);
        run_case("mil255", 1, 0, 255, 0);
        run_case("fare0", 0, 0, 0, 0);
        run_case("wait7", 2, 0, 0, 7);
        op = 2'd0;
        cost = 11'd10;
        wait_upd;
        wait_upd;
        wait_upd;
        step;
        repeat (5) step;
        op = 2'd1;
        mil = 8'd99;
        wait_upd;
        scan_check("midchg_old", 0, 10);
        wait_upd;
        scan_check("midchg_new", 1, 99);
        for (int r = 0; r < 8; r++) begin
            int o = int'($urandom_range(3, 0));
            int c = int'($urandom_range(2047, 0));
            int m = int'($urandom_range(255, 0));
            int t = int'($urandom_range(127, 0));
            run_case($sformatf("rnd%0d", r), o, c, m, t);
        end
        wait_upd;
        repeat (3) step;
        rst = 1'b1;
        step;
        chk("midrst_seg", 32'(seg), 32'hFF);
        chk("midrst_code", 32'(codeout), 32'h00);
        chk("midrst_upd", 32'(upd), 32'd0);
        chk("midrst_seg4", 32'(seg4), 32'hFF);
        chk("midrst_code4", 32'(codeout4), 32'h00);
        rst = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step;
            chk($sformatf("rel_upd%0d", k + 1), 32'(upd), 32'(k == 12));
            chk($sformatf("rel_blank%0d", k + 1), 32'(codeout), 32'h00);
        end
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
